bram_playback_ctrl: RTL and testbench

//  Sequences the BRAM line buffer: loads a waveform from a valid/ready stream,

---
 rtl/bram_playback_ctrl_if.sv | 34 +++
 rtl/bram_playback_ctrl.sv | 173 +++++++++++++++++
 tb/tb_bram_playback_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_playback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_playback_ctrl_if
// Description : Waveform load stream between the PS-side loader (master) and
//               the BRAM playback controller (slave).
//               load_data  - one BRAM line
//               load_valid - load_data valid
//               load_last  - final line of the waveform
//               load_ready - controller accepts the beat
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_playback_ctrl_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_valid;
    logic                  load_last;
    logic                  load_ready;

    modport master (
        output load_data,
        output load_valid,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_data,
        input  load_valid,
        input  load_last,
        output load_ready
    );
endinterface
`default_nettype wire

// File: rtl/bram_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_playback_ctrl
// Description : Sequences the BRAM line buffer: loads a waveform from a
//               valid/ready stream, switches the buffer into generator
//               (playback) mode and tears playback down again.
// Ports       : clk, rst_n         - clock, async active-low reset
//               load_start         - begin a load (IDLE only)
//               ld (slave)         - load stream: data/valid/last/ready
//               play_stop          - abort load/playback, back to IDLE
//               write_rdy          - BRAM interface ready for writes
//               valid_line_out     - generator output valid
//               bram_addr/line_in/we/en - BRAM write port (registered)
//               generator_mode     - BRAM in playback mode
//               rst_gen_mode       - one-cycle generator pointer reset
//               line_count         - lines written by the last load
//               state              - IDLE=0 WAIT_RDY=1 LOAD=2 ARM=3 PLAY=4
//               ovf                - sticky: load exceeded BRAM_DEPTH
//               load_checksum      - XOR of accepted lines (optional)
// Options     : LOAD_CHECKSUM_EN - adds the load_checksum output
// Revision    : 1.0 - initial release
// ============================================================================
module bram_playback_ctrl #(
    parameter  int DATA_WIDTH = 256,
    parameter  int BRAM_DEPTH = 16,
    localparam int ADDR_W     = $clog2(BRAM_DEPTH),
    localparam int CNT_W      = ADDR_W + 1
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   load_start,
    bram_playback_ctrl_if.slave   ld,
    input  wire                   play_stop,
    input  wire                   write_rdy,
    input  wire                   valid_line_out,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_WIDTH-1:0] bram_line_in,
    output logic                  bram_we,
    output logic                  bram_en,
    output logic                  generator_mode,
    output logic                  rst_gen_mode,
    output logic [CNT_W-1:0]      line_count,
    output logic [2:0]            state,
    output logic                  ovf
`ifdef LOAD_CHECKSUM_EN
   ,output logic [DATA_WIDTH-1:0] load_checksum
`endif
);
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WAIT_RDY = 3'd1;
    localparam logic [2:0] c_LOAD     = 3'd2;
    localparam logic [2:0] c_ARM      = 3'd3;
    localparam logic [2:0] c_PLAY     = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_beat;
    logic                  w_at_end;
    logic                  w_full;
    logic                  w_we_nxt;
    logic [ADDR_W-1:0]     w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_line_nxt;
    logic                  w_gen_nxt;
    logic                  w_rgm_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_ovf_nxt;

    // line_count doubles as the write pointer: the next beat lands at its value.
    assign w_full        = (line_count == CNT_W'(BRAM_DEPTH));
    assign w_at_end      = (line_count == CNT_W'(BRAM_DEPTH - 1));
    assign ld.load_ready = (r_state == c_LOAD) && !w_full;

    // play_stop wins over everything outside IDLE, and over load_start in IDLE.
    assign w_stop  = play_stop && (r_state != c_IDLE);
    assign w_start = load_start && !play_stop && (r_state == c_IDLE);
    // A beat coinciding with play_stop is dropped: the stop leaves we=0.
    assign w_beat  = ld.load_valid && ld.load_ready && !play_stop;

    assign state = r_state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:     if (w_start) w_state_nxt = c_WAIT_RDY;
                c_WAIT_RDY: if (write_rdy) w_state_nxt = c_LOAD;
                c_LOAD:     if (w_beat && (ld.load_last || w_at_end)) w_state_nxt = c_ARM;
                c_ARM:      if (valid_line_out) w_state_nxt = c_PLAY;
                c_PLAY:     w_state_nxt = c_PLAY;
                default:    w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_we_nxt   = w_beat;
        w_addr_nxt = bram_addr;
        w_line_nxt = bram_line_in;
        w_cnt_nxt  = line_count;
        w_ovf_nxt  = ovf;
        // generator_mode rises one cycle after ARM is entered
        w_gen_nxt  = ((r_state == c_ARM) || (r_state == c_PLAY)) && !play_stop;
        w_rgm_nxt  = w_start || w_stop;
        if (w_start) begin
            w_cnt_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (w_beat) begin
            w_addr_nxt = line_count[ADDR_W-1:0];
            w_line_nxt = ld.load_data;
            w_cnt_nxt  = line_count + CNT_W'(1);
            // Last BRAM line consumed without load_last: waveform truncated.
            if (w_at_end && !ld.load_last) begin
                w_ovf_nxt = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addr      <= '0;
            bram_line_in   <= '0;
            bram_we        <= 1'b0;
            bram_en        <= 1'b0;
            generator_mode <= 1'b0;
            rst_gen_mode   <= 1'b0;
            line_count     <= '0;
            ovf            <= 1'b0;
        end else begin
            bram_addr      <= w_addr_nxt;
            bram_line_in   <= w_line_nxt;
            bram_we        <= w_we_nxt;
            bram_en        <= w_we_nxt;
            generator_mode <= w_gen_nxt;
            rst_gen_mode   <= w_rgm_nxt;
            line_count     <= w_cnt_nxt;
            ovf            <= w_ovf_nxt;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_cks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cks <= '0;
        end else if (w_start) begin
            r_cks <= '0;
        end else if (w_beat) begin
            r_cks <= r_cks ^ ld.load_data;
        end
    end

    assign load_checksum = r_cks;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_playback_ctrl
// Description : Self-checking bench for bram_playback_ctrl. Stimulus pushes
//               expected BRAM writes into a scoreboard queue; a monitor pops
//               and compares whenever bram_we is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_playback_ctrl;
    localparam int DW    = 256;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic          play_stop;
    logic          write_rdy;
    logic          valid_line_out;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_line_in;
    logic          bram_we;
    logic          bram_en;
    logic          generator_mode;
    logic          rst_gen_mode;
    logic [AW:0]   line_count;
    logic [2:0]    state;
    logic          ovf;
`ifdef LOAD_CHECKSUM_EN
    logic [DW-1:0] load_checksum;
`endif

    bram_playback_ctrl_if #(.DATA_WIDTH(DW)) lif ();

    bram_playback_ctrl #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_start     (load_start),
        .ld             (lif.slave),
        .play_stop      (play_stop),
        .write_rdy      (write_rdy),
        .valid_line_out (valid_line_out),
        .bram_addr      (bram_addr),
        .bram_line_in   (bram_line_in),
        .bram_we        (bram_we),
        .bram_en        (bram_en),
        .generator_mode (generator_mode),
        .rst_gen_mode   (rst_gen_mode),
        .line_count     (line_count),
        .state          (state),
        .ovf            (ovf)
`ifdef LOAD_CHECKSUM_EN
       ,.load_checksum  (load_checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of one load
    wr_t           sb[$];
    int            m_count;
    bit            m_ovf;
    bit            m_in_load;
    logic [DW-1:0] m_cks;
    logic [DW-1:0] fixed_data[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bram_en !== bram_we) chk("we_en_equal", DW'(bram_en), DW'(bram_we));
            if (bram_we === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", DW'(bram_addr), '1);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", DW'(bram_addr), DW'(e.addr));
                    chk("wr_data", bram_line_in, e.data);
                end
            end
        end
    end

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_count = 0; m_ovf = 1'b0; m_cks = '0; m_in_load = 1'b0;
        chk("start_state", DW'(state), DW'(1));
        chk("start_rgm", DW'(rst_gen_mode), DW'(1));
        chk("start_cnt", DW'(line_count), DW'(0));
        chk("start_ovf", DW'(ovf), DW'(0));
    endtask

    task automatic enter_load(input int hold);
        write_rdy = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("wait_state", DW'(state), DW'(1));
            chk("wait_ready", DW'(lif.load_ready), DW'(0));
        end
        write_rdy = 1'b1;
        tick();
        m_in_load = 1'b1;
        chk("load_state", DW'(state), DW'(2));
    endtask

    task automatic load_beats(input int n_offer, input int last_at, input bit rnd);
        int offered = 0;
        int guard   = 0;
        logic [DW-1:0] d;
        bit v, exp_rdy;
        while (offered < n_offer && guard < 200) begin
            guard++;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (fixed_data.size() != 0 && v) d = fixed_data.pop_front();
            else for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
            lif.load_valid = v;
            lif.load_data  = d;
            lif.load_last  = (offered == last_at);
            exp_rdy = m_in_load && (m_count < DEPTH);
            #1;
            chk("load_ready", DW'(lif.load_ready), DW'(exp_rdy));
            if (v) begin
                if (exp_rdy) begin
                    sb.push_back('{addr: AW'(m_count), data: d});
                    m_count++;
                    m_cks ^= d;
                    if (offered == last_at || m_count == DEPTH) begin
                        m_in_load = 1'b0;
                        m_ovf = (offered != last_at);
                    end
                end
                offered++;
            end
            tick();
        end
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;
        if (guard >= 200) chk("load_timeout", DW'(offered), DW'(n_offer));
    endtask

    task automatic check_load_result(input int exp_state);
        tick();
        chk("drain", DW'(sb.size()), DW'(0));
        chk("line_count", DW'(line_count), DW'(m_count));
        chk("ovf", DW'(ovf), DW'(m_ovf));
        chk("post_load_state", DW'(state), DW'(exp_state));
`ifdef LOAD_CHECKSUM_EN
        chk("checksum", load_checksum, m_cks);
`endif
    endtask

    task automatic arm_and_play();
        chk("arm_gen", DW'(generator_mode), DW'(1));
        valid_line_out = 1'b1;
        tick();
        valid_line_out = 1'b0;
        chk("play_state", DW'(state), DW'(4));
        repeat (3) tick();
        chk("play_gen_held", DW'(generator_mode), DW'(1));
    endtask

    task automatic stop();
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        m_in_load = 1'b0;
        chk("stop_state", DW'(state), DW'(0));
        chk("stop_gen", DW'(generator_mode), DW'(0));
        chk("stop_we", DW'(bram_we), DW'(0));
        chk("stop_rgm", DW'(rst_gen_mode), DW'(1));
        chk("stop_cnt_kept", DW'(line_count), DW'(m_count));
        chk("stop_ovf_kept", DW'(ovf), DW'(m_ovf));
        tick();
        chk("stop_rgm_pulse", DW'(rst_gen_mode), DW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_start = 1'b0; play_stop = 1'b0; write_rdy = 1'b0;
        valid_line_out = 1'b0;
        lif.load_valid = 1'b0; lif.load_last = 1'b0; lif.load_data = '0;
        repeat (3) tick();
        chk("rst_state", DW'(state), DW'(0));
        chk("rst_cnt", DW'(line_count), DW'(0));
        chk("rst_ovf", DW'(ovf), DW'(0));
        chk("rst_ready", DW'(lif.load_ready), DW'(0));
        chk("rst_gen", DW'(generator_mode), DW'(0));
        chk("rst_rgm", DW'(rst_gen_mode), DW'(0));
        chk("rst_we", DW'(bram_we), DW'(0));
`ifdef LOAD_CHECKSUM_EN
        chk("rst_cks", load_checksum, '0);
`endif
        rst_n = 1'b1;
        tick();

        // 8 random beats, last on the 8th, then playback
        write_rdy = 1'b1;
        start_load();
        enter_load(0);
        load_beats(8, 7, 1'b0);
        chk("t1_arm_gen_delay", DW'(generator_mode), DW'(0));
        check_load_result(3);
        arm_and_play();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("start_in_play_state", DW'(state), DW'(4));
        chk("start_in_play_rgm", DW'(rst_gen_mode), DW'(0));
        stop();

        // write_rdy held low for 10 cycles
        start_load();
        enter_load(10);
        load_beats(2, 1, 1'b0);
        check_load_result(3);
        stop();

        // 20 beats without last: overflow at 16
        start_load();
        enter_load(0);
        load_beats(20, -1, 1'b0);
        check_load_result(3);
        stop();

        // random load_valid over 5 beats
        start_load();
        chk("ovf_cleared", DW'(ovf), DW'(0));
        enter_load(0);
        load_beats(5, 4, 1'b1);
        check_load_result(3);
        arm_and_play();
        stop();

        // stop in the middle of a load
        start_load();
        enter_load(0);
        load_beats(3, -1, 1'b0);
        check_load_result(2);
        stop();
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        chk("idle_stop_rgm", DW'(rst_gen_mode), DW'(0));
        chk("idle_stop_state", DW'(state), DW'(0));

        // all-A then all-5 lines, then single-line load
        fixed_data.push_back({(DW/4){4'hA}});
        fixed_data.push_back({(DW/4){4'h5}});
        start_load();
        enter_load(0);
        load_beats(2, 1, 1'b0);
        check_load_result(3);
`ifdef LOAD_CHECKSUM_EN
        chk("cks_all_f", load_checksum, {(DW/4){4'hF}});
`endif
        stop();
        start_load();
        enter_load(0);
        load_beats(1, 0, 1'b0);
        check_load_result(3);
        chk("single_line_cnt", DW'(line_count), DW'(1));
        arm_and_play();
        stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
